servo_slew_ctrl: RTL
====================

# servo_slew_ctrl

Command-side controller for the forklift servo PWM stage. Accepts target pulse widths over a valid/ready handshake, clamps them to the mechanically safe range, and slews the commanded width toward the target by a bounded step once per PWM frame. Sits directly upstream of the PWM generator. Consumes that stage's frame-start strobe and drives its `pulse_width` high-time count, so the servo never sees a width jump larger than `STEP` counts between frames.

## Interface
Parameters:
- `WIDTH`, 32: bit width of all pulse-width values.
- `MIN_WIDTH`, 200000: lowest legal pulse width, in clock counts (1.0 ms).
- `MAX_WIDTH`, 400000: highest legal pulse width, in clock counts (2.0 ms).
- `CENTER`, 330000: reset and power-on pulse width (1.65 ms).
- `STEP`, 2000: maximum change of `pulse_width` per frame. Requires `STEP` ≥ 1 and `MIN_WIDTH` ≤ `CENTER` ≤ `MAX_WIDTH`.

Ports:
- `clock_clk`, in, 1: sole clock; all logic on its rising edge.
- `reset_low`, in, 1: asynchronous, active-low reset.
- `cmd_valid`, in, 1: `cmd_width` holds a new target.
- `cmd_ready`, out, 1: pending slot empty; a command can be accepted.
- `cmd_width`, in, `WIDTH`: requested target, unsigned clock counts.
- `frame_start`, in, 1: one-cycle strobe from the PWM stage, marking the start of a frame (its count == 0).
- `pulse_width`, out, `WIDTH`: registered high-time count consumed by the PWM stage.
- `busy`, out, 1: registered; slewing (`pulse_width` ≠ target).
- `at_target`, out, 1: registered; equals `!busy`.
- `clamp_err`, out, 1: one-cycle pulse when an accepted command was out of range.

## Operation
- Handshake:
  - A command is accepted on any cycle with `cmd_valid && cmd_ready`.
  - `cmd_ready` = `!pending_valid` (combinational from the register).
  - `cmd_width` is clamped to [`MIN_WIDTH`, `MAX_WIDTH`] on acceptance.
  - The clamped value is stored in `pending`, and `pending_valid` is set.
- `clamp_err` is registered. It is 1 for exactly the cycle after an acceptance whose raw `cmd_width` was outside the range, and 0 otherwise.
- Target load: on a `frame_start` cycle with `pending_valid`=1:
  - `target` ← `pending`, and `pending_valid` is cleared.
  - The step computed in that same cycle uses the new target.
- Step rule, evaluated on every `frame_start` cycle:
  - Let d = target − `pulse_width`, computed signed in `WIDTH`+1 bits with no wrap.
  - If |d| ≤ `STEP`, `pulse_width` ← target.
  - Otherwise `pulse_width` ← `pulse_width` ± `STEP`, toward the target.
- FSM, updated only on `frame_start` cycles:
  - IDLE → SLEW when the post-load target ≠ `pulse_width` and |d| > `STEP`.
  - SLEW → IDLE on the frame whose step lands on the target.
  - IDLE stays IDLE if the step lands directly (|d| ≤ `STEP`).
  - `busy` = (state == SLEW).
- A new command may be accepted while slewing. It retargets at the next `frame_start`, and slewing continues from the current `pulse_width` (direction may reverse).
- `pulse_width` always stays within [`MIN_WIDTH`, `MAX_WIDTH`].

## Timing
- Reset values (asynchronous, immediate):
  - `pulse_width` = `CENTER`, target = `CENTER`, `pending_valid` = 0, state IDLE.
  - Hence `cmd_ready` = 1, `busy` = 0, `at_target` = 1, `clamp_err` = 0.
- Command to pending: `cmd_ready` falls the cycle after acceptance.
- `frame_start` to output: `pulse_width`, `busy` and `at_target` update in the cycle after the `frame_start` cycle. `cmd_ready` rises in that same cycle if the pending entry was consumed.
- Simultaneous acceptance and `frame_start` (pending empty): the command goes into `pending`. It is not applied this frame; it applies at the next `frame_start`.
- `frame_start` with no pending entry and state IDLE: no change.
- Back-to-back `frame_start` pulses (one per cycle) are legal; each one steps.
- Reset mid-slew: all state returns to its reset value asynchronously, and any pending command is discarded.

## Test plan
Default parameters throughout.
- **Reset:** assert `reset_low`=0 mid-operation.
  - Required: immediately `pulse_width`=330000, `cmd_ready`=1, `busy`=0, `at_target`=1, `clamp_err`=0.
- **Slew up:** accept 340000, then 5 frame strobes.
  - Required: `pulse_width` 332000, 334000, 336000, 338000, 340000.
  - `busy`=1 after frames 1–4 and 0 after frame 5.
- **Small step:** from 330000, accept 331000, then 1 frame.
  - Required: `pulse_width`=331000; `busy` stays 0.
- **Clamping:** accept 500000.
  - Required: `clamp_err` pulses for 1 cycle; the target becomes 400000.
  - Then accept 0: another `clamp_err` pulse; the slew ends at 200000.
- **Backpressure:** accept A=350000, then hold B=300000 valid.
  - Required: `cmd_ready`=0 until the cycle after the next `frame_start`; A is applied, then B is accepted.
  - B is applied on the following frame, and the slew reverses toward 300000.
- **Collision and reset mid-slew:** assert `cmd_valid` in the same cycle as `frame_start`, with pending empty.
  - Required: no target change this frame; the command applies the next frame.
  - Then reset during the slew: `pulse_width`=330000 and the pending entry is dropped.

Source files
------------

// File: rtl/servo_slew_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : servo_slew_ctrl
// Brief    : Clamps servo width commands and slews the PWM high-time by at
//            most STEP counts per frame.
// Revision : 1.0
// ============================================================================
module servo_slew_ctrl #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] MIN_WIDTH = WIDTH'(200000),
    parameter logic [WIDTH-1:0] MAX_WIDTH = WIDTH'(400000),
    parameter logic [WIDTH-1:0] CENTER    = WIDTH'(330000),
    parameter logic [WIDTH-1:0] STEP      = WIDTH'(2000)
) (
    input  logic             clock_clk,
    input  logic             reset_low,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_width,
    input  logic             frame_start,
    output logic [WIDTH-1:0] pulse_width,
    output logic             busy,
    output logic             at_target,
    output logic             clamp_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SLEW = 1'b1
    } state_t;

    localparam logic [WIDTH:0] C_STEP_EXT = {1'b0, STEP};

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  pulse_width_q, pulse_width_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic [WIDTH-1:0]  pending_q, pending_d;
    logic              pending_valid_q, pending_valid_d;
    logic              clamp_err_q, clamp_err_d;

    logic              w_accept;
    logic              w_too_low;
    logic              w_too_high;
    logic [WIDTH-1:0]  w_clamped;
    logic [WIDTH-1:0]  w_target_eff;
    logic signed [WIDTH:0] w_diff;
    logic [WIDTH:0]    w_mag;

    always_ff @(posedge clock_clk or negedge reset_low) begin
        if (!reset_low) begin
            state_q         <= ST_IDLE;
            pulse_width_q   <= CENTER;
            target_q        <= CENTER;
            pending_q       <= CENTER;
            pending_valid_q <= 1'b0;
            clamp_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            pulse_width_q   <= pulse_width_d;
            target_q        <= target_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            clamp_err_q     <= clamp_err_d;
        end
    end

    always_comb begin
        w_accept   = cmd_valid && !pending_valid_q;
        w_too_low  = cmd_width < MIN_WIDTH;
        w_too_high = cmd_width > MAX_WIDTH;
        w_clamped  = w_too_low ? MIN_WIDTH : (w_too_high ? MAX_WIDTH : cmd_width);

        // A frame that consumes the pending slot steps toward the new target.
        w_target_eff = (frame_start && pending_valid_q) ? pending_q : target_q;
        w_diff = $signed({1'b0, w_target_eff}) - $signed({1'b0, pulse_width_q});
        w_mag  = w_diff[WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);

        state_d         = state_q;
        pulse_width_d   = pulse_width_q;
        target_d        = target_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        clamp_err_d     = w_accept && (w_too_low || w_too_high);

        if (w_accept) begin
            pending_d       = w_clamped;
            pending_valid_d = 1'b1;
        end

        if (frame_start) begin
            target_d = w_target_eff;
            if (pending_valid_q) begin
                pending_valid_d = 1'b0;
            end
            if (w_mag <= C_STEP_EXT) begin
                pulse_width_d = w_target_eff;
                state_d       = ST_IDLE;
            end else begin
                pulse_width_d = w_diff[WIDTH] ? (pulse_width_q - STEP) : (pulse_width_q + STEP);
                state_d       = ST_SLEW;
            end
        end
    end

    assign cmd_ready   = !pending_valid_q;
    assign pulse_width = pulse_width_q;
    assign busy        = (state_q == ST_SLEW);
    assign at_target   = (state_q == ST_IDLE);
    assign clamp_err   = clamp_err_q;

endmodule
`default_nettype wire
